// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with start-bit qualification and frame-error detection
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_clk,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [BIT_W-1:0]       bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0]   shift_reg, shift_reg_n;
    logic [DATA_BITS-1:0]   data_n;
    logic                   data_valid_n;
    logic                   frame_error_n;

    logic                   baud_q;
    logic                   tick;
    logic                   rxd_m;
    logic                   rxd_s;

    // baud_clk is already in the clk domain, so a single register finds its rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q <= 1'b0;
        end else begin
            baud_q <= baud_clk;
        end
    end

    assign tick = baud_clk & ~baud_q;

    // Synchronizer resets to the idle line level so reset release never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            data        <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            shift_reg   <= shift_reg_n;
            data        <= data_n;
            data_valid  <= data_valid_n;
            frame_error <= frame_error_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        bit_idx_n     = bit_idx;
        shift_reg_n   = shift_reg;
        data_n        = data;
        data_valid_n  = 1'b0;
        frame_error_n = 1'b0;

        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end

                // Re-check the line at mid start bit to reject glitches
                START: begin
                    if (cnt == CNT_HALF) begin
                        if (!rxd_s) begin
                            state_n   = DATA;
                            cnt_n     = '0;
                            bit_idx_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt == CNT_FULL) begin
                        shift_reg_n = (shift_reg >> 1) |
                                      (DATA_BITS'(rxd_s) << (DATA_BITS - 1));
                        cnt_n       = '0;
                        if (bit_idx == BIT_LAST) begin
                            state_n   = STOP;
                            bit_idx_n = '0;
                        end else begin
                            bit_idx_n = bit_idx + BIT_ONE;
                        end
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt_n = '0;
                        if (rxd_s) begin
                            data_n       = shift_reg;
                            data_valid_n = 1'b1;
                            state_n      = IDLE;
                        end else begin
                            frame_error_n = 1'b1;
                            state_n       = WAIT_IDLE;
                        end
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end

                // A break holds the line low; only a return to idle re-arms the receiver
                WAIT_IDLE: begin
                    if (rxd_s) begin
                        state_n = IDLE;
                    end
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int BIT_CLKS  = 432;
    localparam int TICK_CLKS = 27;

    logic       clk;
    logic       rst_n;
    logic       baud_clk;
    logic       rxd;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    int compared;
    int mismatched;

    int         dv_cnt;
    int         fe_cnt;
    int         both_cnt;
    int         busy_fall_err;
    logic       prev_busy;
    logic       saw_busy;
    logic [7:0] dv_hist [$];

    int         div_cnt;

    uart_rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_clk   (baud_clk),
        .rxd        (rxd),
        .data       (data),
        .data_valid (data_valid),
        .frame_error(frame_error),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Divide-by-27 square wave: one rising edge every 27 clk cycles
    initial begin
        div_cnt  = 0;
        baud_clk = 1'b0;
        forever begin
            @(posedge clk);
            div_cnt  = (div_cnt == TICK_CLKS - 1) ? 0 : div_cnt + 1;
            baud_clk = (div_cnt < 13);
        end
    end

    initial begin
        dv_cnt        = 0;
        fe_cnt        = 0;
        both_cnt      = 0;
        busy_fall_err = 0;
        prev_busy     = 1'b0;
        saw_busy      = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (data_valid) begin
                    dv_cnt++;
                    dv_hist.push_back(data);
                    if (busy !== 1'b0 || prev_busy !== 1'b1) busy_fall_err++;
                end
                if (frame_error) fe_cnt++;
                if (data_valid && frame_error) both_cnt++;
                if (busy) saw_busy = 1'b1;
            end
            prev_busy = busy;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clks(BIT_CLKS);
        end
        rxd = stop_bit;
        wait_clks(BIT_CLKS);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rxd   = 1'b1;
        wait_clks(5);
        compared++;
        if ({data, data_valid, frame_error, busy} !== 11'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got data=%h dv=%b fe=%b busy=%b, want all 0",
                     data, data_valid, frame_error, busy);
        end
        rst_n = 1'b1;
        wait_clks(BIT_CLKS);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_single;
        int dv0, fe0;
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b1);
        wait_clks(BIT_CLKS);
        compared++;
        if (dv_cnt - dv0 !== 1) begin
            mismatched++;
            $display("FAIL single_dv_count: got %0d want 1", dv_cnt - dv0);
        end
        compared++;
        if (data !== 8'h55) begin
            mismatched++;
            $display("FAIL single_data: got %h want 55", data);
        end
        compared++;
        if (fe_cnt - fe0 !== 0) begin
            mismatched++;
            $display("FAIL single_fe_count: got %0d want 0", fe_cnt - fe0);
        end
        compared++;
        if (busy_fall_err !== 0) begin
            mismatched++;
            $display("FAIL single_busy_fall: got %0d bad pulses want 0", busy_fall_err);
        end
    endtask

    task automatic test_back_to_back;
        int dv0;
        dv0 = dv_cnt;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        wait_clks(BIT_CLKS);
        compared++;
        if (dv_cnt - dv0 !== 2) begin
            mismatched++;
            $display("FAIL b2b_dv_count: got %0d want 2", dv_cnt - dv0);
        end else begin
            compared++;
            if (dv_hist[dv0] !== 8'hA3) begin
                mismatched++;
                $display("FAIL b2b_first: got %h want a3", dv_hist[dv0]);
            end
            compared++;
            if (dv_hist[dv0+1] !== 8'h0F) begin
                mismatched++;
                $display("FAIL b2b_second: got %h want 0f", dv_hist[dv0+1]);
            end
        end
        compared++;
        if (data !== 8'h0F) begin
            mismatched++;
            $display("FAIL b2b_data: got %h want 0f", data);
        end
    endtask

    task automatic test_glitch;
        int dv0, fe0;
        dv0      = dv_cnt;
        fe0      = fe_cnt;
        @(negedge clk);
        saw_busy = 1'b0;
        rxd      = 1'b0;
        wait_clks(4 * TICK_CLKS);
        rxd = 1'b1;
        wait_clks(8 * TICK_CLKS);
        compared++;
        if (saw_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL glitch_seen: busy never rose, want 1");
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_busy: got %b want 0 within 8 ticks", busy);
        end
        compared++;
        if ((dv_cnt - dv0) + (fe_cnt - fe0) !== 0) begin
            mismatched++;
            $display("FAIL glitch_pulses: got dv=%0d fe=%0d want 0", dv_cnt - dv0, fe_cnt - fe0);
        end
        compared++;
        if (data !== 8'h0F) begin
            mismatched++;
            $display("FAIL glitch_data: got %h want 0f", data);
        end
    endtask

    task automatic test_frame_error;
        int dv0, fe0;
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        wait_clks(40 * TICK_CLKS);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL ferr_break_busy: got %b want 1", busy);
        end
        rxd = 1'b1;
        wait_clks(2 * BIT_CLKS);
        compared++;
        if (fe_cnt - fe0 !== 1) begin
            mismatched++;
            $display("FAIL ferr_fe_count: got %0d want 1", fe_cnt - fe0);
        end
        compared++;
        if (dv_cnt - dv0 !== 0) begin
            mismatched++;
            $display("FAIL ferr_dv_count: got %0d want 0", dv_cnt - dv0);
        end
        compared++;
        if (data !== 8'h0F) begin
            mismatched++;
            $display("FAIL ferr_data: got %h want 0f", data);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL ferr_release_busy: got %b want 0", busy);
        end
        compared++;
        if (both_cnt !== 0) begin
            mismatched++;
            $display("FAIL ferr_overlap: got %0d want 0", both_cnt);
        end
    endtask

    task automatic test_reset_mid_frame;
        int dv0;
        dv0 = dv_cnt;
        @(negedge clk);
        rxd = 1'b0;
        wait_clks(BIT_CLKS);
        rxd = 1'b1;
        wait_clks(4 * BIT_CLKS + 200);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mid_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        wait_clks(3);
        compared++;
        if ({data, data_valid, frame_error, busy} !== 11'd0) begin
            mismatched++;
            $display("FAIL rst_mid_outputs: got data=%h dv=%b fe=%b busy=%b, want all 0",
                     data, data_valid, frame_error, busy);
        end
        wait_clks(50);
        rst_n = 1'b1;
        wait_clks(2 * BIT_CLKS);
        compared++;
        if (dv_cnt - dv0 !== 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_discard: got dv=%0d busy=%b want 0 0", dv_cnt - dv0, busy);
        end
        send_frame(8'h81, 1'b1);
        wait_clks(BIT_CLKS);
        compared++;
        if (dv_cnt - dv0 !== 1) begin
            mismatched++;
            $display("FAIL rst_mid_dv_count: got %0d want 1", dv_cnt - dv0);
        end
        compared++;
        if (data !== 8'h81) begin
            mismatched++;
            $display("FAIL rst_mid_data: got %h want 81", data);
        end
    endtask

    task automatic test_idle_line;
        int dv0, fe0, busy_hi;
        dv0     = dv_cnt;
        fe0     = fe_cnt;
        busy_hi = 0;
        rxd     = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_hi++;
        end
        compared++;
        if (busy_hi !== 0) begin
            mismatched++;
            $display("FAIL idle_busy: got %0d busy cycles want 0", busy_hi);
        end
        compared++;
        if ((dv_cnt - dv0) + (fe_cnt - fe0) !== 0) begin
            mismatched++;
            $display("FAIL idle_pulses: got dv=%0d fe=%0d want 0", dv_cnt - dv0, fe_cnt - fe0);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        rxd        = 1'b1;
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_error;
        test_reset_mid_frame;
        test_idle_line;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
